// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 transmit master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    TRAIL = 3'd4,
    GAP   = 3'd5
  } spi_state_e;

  localparam int SPI_DATA_WIDTH = 8;

  // Far-end input conditioner: 2-flop synchroniser followed by a 3-cycle
  // debounce. Every edge needs one extra cycle of margin on top of that.
  localparam int SPI_COND_SYNC_DEPTH    = 2;
  localparam int SPI_COND_DEBOUNCE_WAIT = 3;
  localparam int SPI_HALF_PERIOD_MIN    = SPI_COND_SYNC_DEPTH + SPI_COND_DEBOUNCE_WAIT + 1;

endpackage

// File: rtl/spi_half_tick.sv
// Half-period divider: counts 0..HALF_PERIOD-1 while enabled, tick on terminal count.
module spi_half_tick #(
  parameter int HALF_PERIOD = 8,
  parameter int CNT_WIDTH   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == CNT_WIDTH'(HALF_PERIOD - 1));

  // Next count: held at zero while disabled, wraps to zero on terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: one MSB-first full-duplex word per start request.
//
// state | meaning
// IDLE  | cs_n high, waiting for start
// LEAD  | cs_n low, sclk low, first data bit set up on mosi
// HIGH  | sclk high; miso sampled at the end of the phase
// LOW   | sclk low; next mosi bit already presented
// TRAIL | sclk low after the last bit, cs_n still low
// GAP   | cs_n high, busy still high (minimum deselect time)
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int HALF_PERIOD = 8,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  cs_n,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // Shorter half-periods would let the far-end conditioner swallow edges.
  generate
    if (HALF_PERIOD < SPI_HALF_PERIOD_MIN) begin : g_bad_half_period
      $error("spi_master_tx: HALF_PERIOD below synchroniser + debounce minimum");
    end
    if ((2 ** CNT_WIDTH) < HALF_PERIOD) begin : g_bad_cnt_width
      $error("spi_master_tx: CNT_WIDTH too narrow for HALF_PERIOD");
    end
  endgenerate

  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tick;

  spi_half_tick #(
    .HALF_PERIOD (HALF_PERIOD),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_half_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q != IDLE),
    .tick   (tick)
  );

  // Phase sequencing; every output is computed here and registered below.
  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          tx_shift_d = tx_data;
          bit_cnt_d  = BIT_W'(DATA_WIDTH - 1);
          cs_n_d     = 1'b0;
          mosi_d     = tx_data[DATA_WIDTH-1];
          busy_d     = 1'b1;
          state_d    = LEAD;
        end
      end
      LEAD, LOW: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (tick) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso};
          sclk_d     = 1'b0;
          // Last bit leaves through TRAIL; bit_cnt never wraps.
          if (bit_cnt_q == '0) begin
            state_d = TRAIL;
          end else begin
            bit_cnt_d  = bit_cnt_q - 1'b1;
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            mosi_d     = tx_shift_q[DATA_WIDTH-2];
            state_d    = LOW;
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          cs_n_d    = 1'b1;
          mosi_d    = 1'b0;
          rx_data_d = rx_shift_q;
          done_d    = 1'b1;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign cs_n    = cs_n_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;

endmodule
